// File: rtl/divs_x3y3.sv
// Signed restoring divider: latches x/y from io_in, produces a truncated quotient and a
// remainder that takes the sign of the dividend, with a fixed five-state sequence per operand pair.
module divs_x3y3 #(
  parameter int X_WIDTH = 3,
  parameter int Y_WIDTH = 3
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int CW = $clog2(X_WIDTH);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, FIX, DONE} state_t;

  logic               w_clk, w_rst_n;
  logic [X_WIDTH-1:0] w_x, w_xabs, w_rmag;
  logic [Y_WIDTH-1:0] w_y, w_yabs;
  logic [Y_WIDTH:0]   w_trial, w_diff;
  logic               w_ge;
  state_t             w_next;

  state_t             r_state;
  logic [X_WIDTH-1:0] r_x, r_xmag, r_qmag, r_q, r_r;
  logic [Y_WIDTH-1:0] r_y, r_ymag;
  logic [Y_WIDTH:0]   r_rem;
  logic [CW-1:0]      r_cnt;
  logic               r_sign, r_err;

  assign w_clk   = io_in[0];
  assign w_rst_n = io_in[1];
  assign w_x     = io_in[2 +: X_WIDTH];
  assign w_y     = io_in[2+X_WIDTH +: Y_WIDTH];

  // Magnitudes are unsigned, so the most negative operand maps to 2^(W-1).
  assign w_xabs = w_x[X_WIDTH-1] ? -w_x : w_x;
  assign w_yabs = w_y[Y_WIDTH-1] ? -w_y : w_y;

  // One restoring step: shift in the next dividend bit (MSB first), subtract if it fits.
  assign w_trial = {r_rem[Y_WIDTH-1:0], r_xmag[r_cnt]};
  assign w_ge    = w_trial >= {1'b0, r_ymag};
  assign w_diff  = w_trial - {1'b0, r_ymag};
  assign w_rmag  = X_WIDTH'(r_rem);

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = LOAD;
      LOAD: w_next = DIV;
      DIV:  w_next = (r_cnt != '0) ? DIV : FIX;
      FIX:  w_next = DONE;
      DONE: if ({w_y, w_x} != {r_y, r_x}) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_xmag <= '0;
      r_ymag <= '0;
      r_sign <= 1'b0;
      r_rem  <= '0;
      r_qmag <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_x    <= w_x;
          r_y    <= w_y;
          r_xmag <= w_xabs;
          r_ymag <= w_yabs;
          r_sign <= w_x[X_WIDTH-1] ^ w_y[Y_WIDTH-1];
          r_rem  <= '0;
          r_qmag <= '0;
          r_cnt  <= CW'(X_WIDTH-1);
        end
        DIV: begin
          r_rem  <= w_ge ? w_diff : w_trial;
          r_qmag <= {r_qmag[X_WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt - 1'b1;
        end
        FIX: begin
          if (r_y == '0) begin
            r_q   <= '0;
            r_r   <= r_x;
            r_err <= 1'b1;
          end else if (r_x == {1'b1, {(X_WIDTH-1){1'b0}}} && (&r_y)) begin
            r_q   <= r_x;
            r_r   <= '0;
            r_err <= 1'b1;
          end else begin
            r_q   <= r_sign ? -r_qmag : r_qmag;
            r_r   <= r_x[X_WIDTH-1] ? -w_rmag : w_rmag;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_out = {(r_state == DONE), r_err, r_r, r_q};

endmodule

// File: tb/tb_divs_x3y3.sv
// Scoreboarded random/directed bench for divs_x3y3: a reference model based on integer division
// queues the expected result and its ready cycle, and a monitor checks every rising edge of ready.
module tb_divs_x3y3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] x = 3'd3, y = 3'd2;
  logic [7:0] io_in, io_out;
  int         cyc = 0;
  int         n_cmp = 0, n_bad = 0;
  logic [2:0] last_x, last_y;
  logic       prev_ready = 1'b0;

  typedef struct {
    logic [6:0] res;   // {err, r, q}
    int         due;
  } exp_t;
  exp_t sb[$];

  assign io_in = {y, x, rst_n, clk};

  divs_x3y3 dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [6:0] model(input logic [2:0] a, input logic [2:0] b);
    int xs, ys, qi, ri;
    logic [2:0] qb, rb;
    logic e;
    xs = $signed(a);
    ys = $signed(b);
    if (ys == 0) begin
      qi = 0; ri = xs; e = 1'b1;
    end else if (xs == -4 && ys == -1) begin
      qi = -4; ri = 0; e = 1'b1;
    end else begin
      qi = xs / ys; ri = xs % ys; e = 1'b0;
    end
    qb = qi[2:0];
    rb = ri[2:0];
    return {e, rb, qb};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d cyc=%0d)", name, act, exp,
               $signed(x), $signed(y), cyc);
    end
  endtask

  // Monitor: each rising edge of ready must match the oldest queued expectation.
  always @(negedge clk) begin
    if (io_out[7] && !prev_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", int'(io_out[6:0]), int'(e.res));
        check("latency", cyc, e.due);
      end
    end
    prev_ready = io_out[7];
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) return;
    end
    check("ready_timeout", 0, 1);
    sb.delete();
  endtask

  task automatic apply(input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    if (a == last_x && b == last_y) return;
    x = a; y = b;
    last_x = a; last_y = b;
    e.res = model(a, b);
    e.due = cyc + 6;
    sb.push_back(e);
    wait_done();
  endtask

  initial begin
    logic [6:0] old;
    exp_t e;
    last_x = x; last_y = y;

    repeat (3) @(negedge clk);
    #1 check("reset_out", int'(io_out), 0);
    rst_n = 1'b1;
    e.res = model(x, y);
    e.due = cyc + 6;
    sb.push_back(e);
    wait_done();

    apply(3'b010, 3'b000);
    apply(3'b100, 3'b111);
    apply(3'b100, 3'b001);
    apply(3'b101, 3'b010);
    apply(3'b011, 3'b110);

    // Operand change in DONE: ready falls next edge, old result held until FIX.
    apply(3'b011, 3'b010);
    old = io_out[6:0];
    x = 3'b011; y = 3'b011;
    last_x = x; last_y = y;
    e.res = model(x, y);
    e.due = cyc + 6;
    sb.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("ready_low", int'(io_out[7]), 0);
      check("hold", int'(io_out[6:0]), int'(old));
    end
    wait_done();

    for (int i = 0; i < 64; i++) apply(i[2:0], i[5:3]);
    for (int i = 0; i < 30; i++) apply(3'($urandom), 3'($urandom));

    // Reset in the second DIV cycle aborts; nothing is queued for the aborted operation.
    x = (last_x == 3'b001) ? 3'b110 : 3'b001;
    y = 3'b011;
    last_x = x; last_y = y;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    check("abort_out", int'(io_out), 0);
    @(negedge clk); #1;
    check("abort_hold", int'(io_out), 0);
    rst_n = 1'b1;
    e.res = model(x, y);
    e.due = cyc + 6;
    sb.push_back(e);
    wait_done();

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divs_x3y3.md
DIVS_X3Y3 -- requirements
Module: divs_x3y3

Interface
REQ-001 Parameter X_WIDTH, default 3: dividend width in bits, two's complement.
REQ-002 Parameter Y_WIDTH, default 3: divisor width in bits, two's complement.
REQ-003 Top-level ports SHALL be exactly io_in (input, 8 bits) and io_out (output, 8 bits); the fields below are bit slices of these ports.
REQ-004 clk  input  1  io_in[0]; the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  io_in[1]; synchronous, active-low (0 = reset).
REQ-006 x  input  3  io_in[4:2]; signed dividend.
REQ-007 y  input  3  io_in[7:5]; signed divisor.
REQ-008 q  output  3  io_out[2:0]; signed quotient, truncated toward zero.
REQ-009 r  output  3  io_out[5:3]; signed remainder, sign follows dividend.
REQ-010 err  output  1  io_out[6]; 1 = divide-by-zero or quotient overflow.
REQ-011 ready  output  1  io_out[7]; 1 = q/r/err valid for the currently latched operands.

Function
REQ-012 States SHALL be IDLE, LOAD, DIV, FIX and DONE; exactly one state per clock cycle.
REQ-013 Transitions: IDLE->LOAD unconditionally; LOAD->DIV; DIV->DIV while the iteration counter is nonzero, else DIV->FIX; FIX->DONE; DONE->LOAD when {y,x} differs from the latched operands, else DONE->DONE.
REQ-014 The LOAD edge SHALL latch x and y, store |x| and |y| as 3-bit unsigned values (|-4| = 4), store sign = x[2]^y[2], clear the 4-bit partial remainder, and set the iteration counter to 2.
REQ-015 DIV SHALL perform restoring division: one quotient bit per cycle, MSB first, exactly 3 DIV cycles; the counter decrements on each DIV edge.
REQ-016 The FIX edge SHALL apply signs: q = sign ? -qmag : qmag; r = x[2] ? -rmag : rmag; err = 0, unless REQ-017 or REQ-018 applies.
REQ-017 Divide-by-zero (y = 0): q = 000, r = x, err = 1.
REQ-018 Overflow (x = -4, y = -1): q = 100, r = 000, err = 1.
REQ-019 x = -4 with y = 1 is not an overflow: q = 100, r = 000, err = 0.
REQ-020 Latency SHALL be fixed for every operand pair, including error cases: ready rises 4 edges after the LOAD edge that captured the operands.
REQ-021 ready SHALL be 1 only in DONE and SHALL fall on the edge that moves DONE->LOAD.
REQ-022 q, r and err SHALL update only on the FIX edge and SHALL hold their values in all other states.
REQ-023 Changes on x/y outside the DONE state SHALL be ignored; they are detected by the DONE comparison after the current result completes.
REQ-024 In DONE, an operand change seen at edge e SHALL give LOAD during the cycle after e, capture at edge e+1 and ready = 1 after edge e+5.

Reset
REQ-025 An edge with reset = 0 SHALL force state IDLE and clear q, r, err, ready, the latched operands, the counter and the partial remainder, regardless of the current state.
REQ-026 Reset asserted mid-DIV SHALL abort the operation; no partial result may appear on io_out.
REQ-027 After reset is released: edge 1 gives IDLE->LOAD, edge 2 captures the operands, and ready = 1 after edge 6.

Verification
REQ-028 Reset release with x = 011, y = 010 -> after edge 6: q = 001, r = 001, err = 0, ready = 1; ready = 0 before edge 6.
REQ-029 Exhaustive sweep of all 64 (x, y) pairs, waiting for ready each time -> q and r match truncated signed division, e.g. -3/2 gives q = 111, r = 111, and 3/-2 gives q = 111, r = 001.
REQ-030 x = 010, y = 000 -> q = 000, r = 010, err = 1, with the same latency as a normal divide.
REQ-031 x = 100, y = 111 -> q = 100, r = 000, err = 1; then x = 100, y = 001 -> q = 100, r = 000, err = 0.
REQ-032 In DONE, change y from 010 to 011 with x = 011 -> ready falls at the next edge, old q/r are held until the FIX edge, then q = 001, r = 000 and ready = 1 five edges after the change was seen.
REQ-033 Drive reset = 0 during the second DIV cycle -> next edge: all of io_out = 0; after release, the full REQ-027 sequence repeats.
